// File: rtl/sync_fifo_pkg.sv
// ============================================================================
// Module : sync_fifo_pkg
// Brief  : Shared sizing helpers, threshold legality check and count-op enum
//          for the single-clock FIFO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sync_fifo_pkg;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  function automatic int unsigned fifo_depth(input int unsigned adrrsize);
    return 32'd1 << adrrsize;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned adrrsize);
    return adrrsize + 32'd1;
  endfunction

  function automatic bit thresh_ok(input int unsigned adrrsize,
                                   input int          afull,
                                   input int          aempty);
    int depth;
    depth = int'(fifo_depth(adrrsize));
    return (afull >= 1) && (afull <= depth) &&
           (aempty >= 0) && (aempty <= depth - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_mem.sv
// ============================================================================
// Module : sync_fifo_mem
// Brief  : DEPTH x DATA_WIDTH storage, synchronous write, asynchronous read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADRRSIZE   = 3
) (
  input  logic                  clk,
  input  logic                  i_wen,
  input  logic [ADRRSIZE-1:0]   i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADRRSIZE-1:0]   i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int c_depth = int'(fifo_depth(ADRRSIZE));

  // Contents are never reset; the pointers alone define what is valid.
  logic [DATA_WIDTH-1:0] r_mem [c_depth];

  always_ff @(posedge clk) begin
    if (i_wen) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module : sync_fifo
// Brief  : Single-clock FIFO with count, almost-full/empty flags and a
//          registered read port. Optional macro SYNC_FIFO_ERR_FLAGS_EN adds
//          sticky overflow/underflow outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADRRSIZE      = 3,
  parameter int AFULL_THRESH  = 6,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wfull,
  output logic                  walmost_full,
  input  logic                  rinc,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [ADRRSIZE:0]     count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int c_pw = int'(ptr_width(ADRRSIZE));
  localparam logic [c_pw-1:0] c_afull  = c_pw'(AFULL_THRESH);
  localparam logic [c_pw-1:0] c_aempty = c_pw'(AEMPTY_THRESH);

  generate
    if (!thresh_ok(ADRRSIZE, AFULL_THRESH, AEMPTY_THRESH)) begin : g_thresh_check
      $error("sync_fifo: AFULL_THRESH/AEMPTY_THRESH out of range");
    end
  endgenerate

  logic [c_pw-1:0]       r_wptr;
  logic [c_pw-1:0]       r_rptr;
  logic [c_pw-1:0]       r_count;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvalid;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wacc;
  logic                  w_racc;
  logic [DATA_WIDTH-1:0] w_mem_rdata;
  cnt_op_e               w_cnt_op;

  // Equal low bits with differing wrap bits means the writer is a lap ahead.
  assign w_full  = (r_wptr[c_pw-1] != r_rptr[c_pw-1]) &&
                   (r_wptr[c_pw-2:0] == r_rptr[c_pw-2:0]);
  assign w_empty = (r_wptr == r_rptr);
  assign w_wacc  = winc && !w_full;
  assign w_racc  = rinc && !w_empty;

  always_comb begin
    w_cnt_op = CNT_HOLD;
    if (w_wacc && !w_racc) begin
      w_cnt_op = CNT_INC;
    end else if (w_racc && !w_wacc) begin
      w_cnt_op = CNT_DEC;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADRRSIZE   (ADRRSIZE)
  ) u_mem (
    .clk     (clk),
    .i_wen   (w_wacc),
    .i_waddr (r_wptr[c_pw-2:0]),
    .i_wdata (wdata),
    .i_raddr (r_rptr[c_pw-2:0]),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      if (w_wacc) begin
        r_wptr <= r_wptr + c_pw'(1);
      end
      if (w_racc) begin
        r_rptr  <= r_rptr + c_pw'(1);
        r_rdata <= w_mem_rdata;
      end
      r_rvalid <= w_racc;
      case (w_cnt_op)
        CNT_INC: r_count <= r_count + c_pw'(1);
        CNT_DEC: r_count <= r_count - c_pw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (winc && w_full) begin
        r_overflow <= 1'b1;
      end
      if (rinc && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

  assign wfull         = w_full;
  assign rempty        = w_empty;
  assign count         = r_count;
  assign walmost_full  = (r_count >= c_afull);
  assign ralmost_empty = (r_count <= c_aempty);
  assign rdata         = r_rdata;
  assign rvalid        = r_rvalid;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo.sv
// ============================================================================
// Module : tb_sync_fifo
// Brief  : Self-checking bench for sync_fifo against a queue-based model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo;

  localparam int DW     = 8;
  localparam int AS     = 3;
  localparam int DEPTH  = 8;
  localparam int AFULL  = 6;
  localparam int AEMPTY = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          winc;
  logic [DW-1:0] wdata;
  logic          wfull;
  logic          walmost_full;
  logic          rinc;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          rempty;
  logic          ralmost_empty;
  logic [AS:0]   count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  sync_fifo #(
    .DATA_WIDTH    (DW),
    .ADRRSIZE      (AS),
    .AFULL_THRESH  (AFULL),
    .AEMPTY_THRESH (AEMPTY)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .winc          (winc),
    .wdata         (wdata),
    .wfull         (wfull),
    .walmost_full  (walmost_full),
    .rinc          (rinc),
    .rdata         (rdata),
    .rvalid        (rvalid),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .count         (count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    .overflow      (overflow),
    .underflow     (underflow)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_rdata;
  logic          m_rvalid;
  logic          m_ovf;
  logic          m_unf;

  int n_checks = 0;
  int n_pass   = 0;

  // Drive one clock of stimulus, then advance the model by the same edge.
  task automatic cycle(input logic w, input logic [DW-1:0] d,
                       input logic r, input logic rs);
    bit full;
    bit empty;
    winc  = w;
    wdata = d;
    rinc  = r;
    rst   = rs;
    @(posedge clk);
    #1;
    if (rs) begin
      mq.delete();
      m_rdata  = '0;
      m_rvalid = 1'b0;
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
    end else begin
      full  = (mq.size() == DEPTH);
      empty = (mq.size() == 0);
      if (w && full)  m_ovf = 1'b1;
      if (r && empty) m_unf = 1'b1;
      m_rvalid = r && !empty;
      if (m_rvalid) m_rdata = mq.pop_front();
      if (w && !full) mq.push_back(d);
    end
    winc = 1'b0;
    rinc = 1'b0;
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (rempty !== 1'b1) $display("FAIL reset_rempty: got %0b want 1", rempty);
    else n_pass++;
    n_checks++;
    if (ralmost_empty !== 1'b1) $display("FAIL reset_raempty: got %0b want 1", ralmost_empty);
    else n_pass++;
    n_checks++;
    if (wfull !== 1'b0 || walmost_full !== 1'b0)
      $display("FAIL reset_full: got wfull=%0b wafull=%0b want 0/0", wfull, walmost_full);
    else n_pass++;
    n_checks++;
    if (count !== 4'd0) $display("FAIL reset_count: got %0d want 0", count);
    else n_pass++;
    n_checks++;
    if (rvalid !== 1'b0 || rdata !== 8'h00)
      $display("FAIL reset_rdata: got rvalid=%0b rdata=%h want 0/00", rvalid, rdata);
    else n_pass++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, DW'(8'h11 * (i + 1)), 1'b0, 1'b0);
      n_checks++;
      if (count !== 4'(i + 1) || walmost_full !== ((i + 1) >= AFULL) || wfull !== (i == DEPTH - 1))
        $display("FAIL fill_%0d: got count=%0d wafull=%0b wfull=%0b want %0d/%0b/%0b",
                 i, count, walmost_full, wfull, i + 1, (i + 1) >= AFULL, i == DEPTH - 1);
      else n_pass++;
    end
    cycle(1'b1, 8'h99, 1'b0, 1'b0);
    n_checks++;
    if (count !== 4'd8 || wfull !== 1'b1)
      $display("FAIL fill_drop: got count=%0d wfull=%0b want 8/1", count, wfull);
    else n_pass++;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL overflow_set: got %0b want 1", overflow);
    else n_pass++;
`endif
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if (rvalid !== 1'b1 || rdata !== DW'(8'h11 * (i + 1)))
        $display("FAIL drain_%0d: got rvalid=%0b rdata=%h want 1/%h",
                 i, rvalid, rdata, DW'(8'h11 * (i + 1)));
      else n_pass++;
    end
    n_checks++;
    if (rempty !== 1'b1 || count !== 4'd0)
      $display("FAIL drain_empty: got rempty=%0b count=%0d want 1/0", rempty, count);
    else n_pass++;
    cycle(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (rvalid !== 1'b0 || rdata !== 8'h88)
      $display("FAIL drain_extra: got rvalid=%0b rdata=%h want 0/88", rvalid, rdata);
    else n_pass++;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    n_checks++;
    if (underflow !== 1'b1) $display("FAIL underflow_set: got %0b want 1", underflow);
    else n_pass++;
`endif
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    n_checks++;
    if (count !== 4'd4) $display("FAIL b2b_prefill: got %0d want 4", count);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, DW'($urandom), 1'b1, 1'b0);
      n_checks++;
      if (count !== 4'd4 || rvalid !== 1'b1 || rdata !== m_rdata)
        $display("FAIL b2b_%0d: got count=%0d rvalid=%0b rdata=%h want 4/1/%h",
                 i, count, rvalid, rdata, m_rdata);
      else n_pass++;
    end
  endtask

  task automatic test_full_empty_simul();
    logic [DW-1:0] oldest;
    for (int i = 0; i < 4; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    n_checks++;
    if (wfull !== 1'b1) $display("FAIL simul_prefull: got wfull=%0b want 1", wfull);
    else n_pass++;
    oldest = mq[0];
    cycle(1'b1, 8'hEE, 1'b1, 1'b0);
    n_checks++;
    if (count !== 4'd7 || rvalid !== 1'b1 || rdata !== oldest)
      $display("FAIL simul_full: got count=%0d rvalid=%0b rdata=%h want 7/1/%h",
               count, rvalid, rdata, oldest);
    else n_pass++;
    for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (rempty !== 1'b1 || rdata !== m_rdata)
      $display("FAIL simul_drain: got rempty=%0b rdata=%h want 1/%h", rempty, rdata, m_rdata);
    else n_pass++;
    cycle(1'b1, 8'h5A, 1'b1, 1'b0);
    n_checks++;
    if (count !== 4'd1 || rvalid !== 1'b0 || rempty !== 1'b0)
      $display("FAIL simul_empty: got count=%0d rvalid=%0b rempty=%0b want 1/0/0",
               count, rvalid, rempty);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    n_checks++;
    if (count !== 4'd5) $display("FAIL rstmid_pre: got %0d want 5", count);
    else n_pass++;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL rstmid_ovf_pre: got %0b want 1", overflow);
    else n_pass++;
`endif
    cycle(1'b0, '0, 1'b1, 1'b1);
    n_checks++;
    if (count !== 4'd0 || rempty !== 1'b1 || rvalid !== 1'b0 || rdata !== 8'h00)
      $display("FAIL rstmid_post: got count=%0d rempty=%0b rvalid=%0b rdata=%h want 0/1/0/00",
               count, rempty, rvalid, rdata);
    else n_pass++;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    n_checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0)
      $display("FAIL rstmid_flags: got ovf=%0b unf=%0b want 0/0", overflow, underflow);
    else n_pass++;
`endif
  endtask

  task automatic test_random();
    int wbias;
    int errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      // Alternate fill-heavy and drain-heavy phases to reach both ends.
      wbias = ((i / 40) % 2 == 0) ? 75 : 25;
      cycle($urandom_range(0, 99) < wbias, DW'($urandom),
            $urandom_range(0, 99) < (100 - wbias), $urandom_range(0, 199) == 0);
      n_checks++;
      if (count !== 4'(mq.size()) || wfull !== (mq.size() == DEPTH) ||
          rempty !== (mq.size() == 0) || walmost_full !== (mq.size() >= AFULL) ||
          ralmost_empty !== (mq.size() <= AEMPTY)) begin
        if (errs < 10)
          $display("FAIL rand_flags_%0d: got count=%0d wf=%0b re=%0b waf=%0b rae=%0b want count=%0d",
                   i, count, wfull, rempty, walmost_full, ralmost_empty, mq.size());
        errs++;
      end else n_pass++;
      n_checks++;
      if (rvalid !== m_rvalid || rdata !== m_rdata) begin
        if (errs < 10)
          $display("FAIL rand_data_%0d: got rvalid=%0b rdata=%h want %0b/%h",
                   i, rvalid, rdata, m_rvalid, m_rdata);
        errs++;
      end else n_pass++;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      n_checks++;
      if (overflow !== m_ovf || underflow !== m_unf) begin
        if (errs < 10)
          $display("FAIL rand_err_%0d: got ovf=%0b unf=%0b want %0b/%0b",
                   i, overflow, underflow, m_ovf, m_unf);
        errs++;
      end else n_pass++;
`endif
    end
  endtask

  initial begin
    rst      = 1'b1;
    winc     = 1'b0;
    rinc     = 1'b0;
    wdata    = '0;
    m_rdata  = '0;
    m_rvalid = 1'b0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_full_empty_simul();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock, parametrised FIFO: storage array plus full/empty control, occupancy count, programmable almost-full/almost-empty flags and a registered read port with a valid strobe. It is the same-clock-domain counterpart of the team's dual-pointer FIFO storage. It buffers streams between blocks sharing one clock, e.g. UART TX/RX staging and ALU command queues.

Parameters:
DATA_WIDTH, 8, width of each data word in bits
ADRRSIZE, 3, address bits; DEPTH = 2^ADRRSIZE words
AFULL_THRESH, 6, walmost_full asserts when count >= this value (1..DEPTH)
AEMPTY_THRESH, 1, ralmost_empty asserts when count <= this value (0..DEPTH-1)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous reset, active-high
winc  input  1  write request
wdata  input  DATA_WIDTH  write data
wfull  output  1  FIFO full
walmost_full  output  1  count >= AFULL_THRESH
rinc  input  1  read request
rdata  output  DATA_WIDTH  registered read data
rvalid  output  1  rdata holds a newly popped word this cycle
rempty  output  1  FIFO empty
ralmost_empty  output  1  count <= AEMPTY_THRESH
count  output  ADRRSIZE+1  current occupancy, 0..DEPTH

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). Reset is sampled only on rising clk.
- Reset values: wptr = 0, rptr = 0, count = 0, rempty = 1, wfull = 0, walmost_full = 0, ralmost_empty = 1, rdata = 0, rvalid = 0.
- Pointers: wptr and rptr are ADRRSIZE+1 bits. The low ADRRSIZE bits address memory; the MSB is a wrap bit. Pointers wrap naturally modulo 2*DEPTH.
- Full/empty:
  - wfull = 1 when the pointer MSBs differ and the low bits are equal.
  - rempty = 1 when the pointers are equal.
  - Both flags are derived from registered pointers, so they are valid in the cycle after the edge that changed them.
- Write accept: wacc = winc && !wfull. On accept, mem[wptr low] <= wdata and wptr increments.
- Read accept: racc = rinc && !rempty. On accept, rdata <= mem[rptr low] and rptr increments. rvalid = 1 in the following cycle, and only then.
- When no read is accepted, rdata holds its last value and rvalid = 0.
- Read latency: one cycle from the accepting edge to rdata/rvalid.
- Write-to-read latency: a word written at edge N can be accepted by a read at edge N+1 at the earliest (rempty deasserts after edge N).
- Count update:
  - +1 on wacc only.
  - -1 on racc only.
  - Unchanged on both or neither.
  - Never exceeds DEPTH and never underflows.
- Simultaneous events:
  - Full + winc + rinc: only the read is accepted. The write is dropped and count becomes DEPTH-1.
  - Empty + winc + rinc: only the write is accepted; rvalid stays 0.
  - Neither full nor empty: both are accepted in the same cycle and count is unchanged.
- Dropped requests: a write while full and a read while empty are silently ignored. Memory and pointers are unchanged.
- walmost_full and ralmost_empty are combinational compares on the registered count.
- Reset mid-operation: all contents are logically discarded. Memory is not cleared; the pointers reset. Any rvalid pending from the reset edge is suppressed.

Optional Feature:
Macro: SYNC_FIFO_ERR_FLAGS_EN
- Defined: two extra outputs, overflow and underflow (1 bit each), both reset to 0.
  - overflow becomes 1 on any edge with winc && wfull.
  - underflow becomes 1 on any edge with rinc && rempty.
  - Both are sticky until rst.
- Not defined: the ports are absent and dropped requests leave no trace.

Decomposition:
- Shared package/include (fifo_defs): DEPTH derivation (1 << ADRRSIZE), pointer width ADRRSIZE+1, and the legal threshold range checks.
- Sub-module sync_fifo_mem: DEPTH x DATA_WIDTH array, synchronous write gated by wacc, asynchronous read at the read address.
- Top level holds the pointers, count, flags and the rdata/rvalid register.

Test Plan:
1. Reset, then idle: rempty = 1, ralmost_empty = 1, wfull = 0, count = 0, rvalid = 0, rdata = 0x00.
2. Write 0x11..0x88 (8 words) on consecutive cycles:
   - walmost_full rises after the 6th write.
   - wfull = 1 and count = 8 after the 8th write.
   - A 9th write of 0x99 is dropped; count stays 8.
3. Read 8 times from full: rdata = 0x11..0x88 in order, each with rvalid one cycle after rinc. rempty = 1 after the 8th read; a 9th rinc produces rvalid = 0.
4. Simultaneous winc + rinc at count = 4: count stays 4, and data order is preserved through 20 cycles of pointer wrap-around.
5. At full, assert winc + rinc together: the read returns the oldest word, the write is dropped, count = 7. At empty, winc + rinc together: write accepted, count = 1, rvalid = 0.
6. Assert rst at count = 5 in the same cycle as rinc:
   - Next cycle: count = 0, rempty = 1, rvalid = 0.
   - With SYNC_FIFO_ERR_FLAGS_EN defined, a prior overflow clears to 0.
